// File: rtl/r2fft_tribuf_pkg.sv
// rtl/r2fft_tribuf_pkg.sv - shared phase constants, bank roles and sequencer state for the FFT tri-buffer ring
package r2fft_tribuf_pkg;

  localparam logic [1:0] PHASE_0 = 2'd0;
  localparam logic [1:0] PHASE_1 = 2'd1;
  localparam logic [1:0] PHASE_2 = 2'd2;

  // Role a bank plays in a given phase; the bus muxes key their selects off these.
  typedef enum logic [1:0] {
    MODE_INPUT = 2'd0,
    MODE_FFT   = 2'd1,
    MODE_DMA   = 2'd2
  } tribuf_mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SWAP   = 3'd2,
    LAUNCH = 3'd3,
    DRAIN  = 3'd4
  } tribuf_state_t;

  function automatic logic [1:0] next_phase(input logic [1:0] phase);
    return (phase == PHASE_2) ? PHASE_0 : phase + 2'd1;
  endfunction

endpackage

// File: rtl/tribuf_phase_ctrl.sv
// rtl/tribuf_phase_ctrl.sv - rotates the input/FFT/DMA bank roles and launches the FFT and DMA engines
module tribuf_phase_ctrl
  import r2fft_tribuf_pkg::*;
#(
  parameter int FFT_N = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             istream_ready,
  input  logic             istream_done,
  output logic             fft_start,
  input  logic             fft_done,
  output logic             dma_start,
  input  logic             dma_done,
  output logic [1:0]       tribuf_status,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] overrun_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // FFT_N only sizes frame bookkeeping at the integration level; nothing here depends on it.
  if (FFT_N < 1) begin : g_fft_n_invalid
  end

  tribuf_state_t state;

  logic in_full;
  logic fft_busy;
  logic dma_busy;
  logic fft_valid;
  logic dma_valid;

  logic in_accept;
  logic in_overrun;
  logic in_full_eff;
  logic units_idle_eff;

  // Events arriving this cycle count toward the rotate/drain decisions so a
  // rotation lands one cycle after the last blocking event.
  always_comb begin
    in_accept      = istream_done & istream_ready;
    in_overrun     = istream_done & ~istream_ready;
    in_full_eff    = in_full | in_accept;
    units_idle_eff = ~(fft_busy & ~fft_done) & ~(dma_busy & ~dma_done);
  end

  assign busy = fft_busy | dma_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tribuf_status <= PHASE_0;
      istream_ready <= 1'b0;
      fft_start     <= 1'b0;
      dma_start     <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
      in_full       <= 1'b0;
      fft_busy      <= 1'b0;
      dma_busy      <= 1'b0;
      fft_valid     <= 1'b0;
      dma_valid     <= 1'b0;
    end else begin
      fft_start <= 1'b0;
      dma_start <= 1'b0;

      // A done in the same cycle as its own start is dropped; stray dones clear nothing.
      if (fft_start)     fft_busy <= 1'b1;
      else if (fft_done) fft_busy <= 1'b0;
      if (dma_start)     dma_busy <= 1'b1;
      else if (dma_done) dma_busy <= 1'b0;

      if (in_accept) begin
        in_full       <= 1'b1;
        istream_ready <= 1'b0;
      end

      if (in_overrun && overrun_count != '1)
        overrun_count <= overrun_count + CNT_ONE;

      case (state)
        IDLE: begin
          if (enable) state <= LAUNCH;
        end
        WAIT: begin
          if (in_full_eff && units_idle_eff) begin
            state <= SWAP;
          end else if (!enable && !in_full_eff) begin
            state         <= DRAIN;
            istream_ready <= 1'b0;
          end
        end
        SWAP: begin
          tribuf_status <= next_phase(tribuf_status);
          dma_valid     <= fft_valid;
          fft_valid     <= 1'b1;
          in_full       <= 1'b0;
          frame_count   <= frame_count + CNT_ONE;
          // Starts are registered here so they are high during LAUNCH; the
          // FFT bank always holds fresh input after a swap.
          fft_start     <= 1'b1;
          dma_start     <= fft_valid;
          state         <= LAUNCH;
        end
        LAUNCH: begin
          istream_ready <= 1'b1;
          state         <= WAIT;
        end
        DRAIN: begin
          if (units_idle_eff) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tribuf_phase_ctrl.sv
// tb/tb_tribuf_phase_ctrl.sv - scoreboard bench for tribuf_phase_ctrl
module tb_tribuf_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst, enable, istream_done, fft_done, dma_done;
  logic        istream_ready, fft_start, dma_start, busy;
  logic [1:0]  tribuf_status;
  logic [15:0] frame_count, overrun_count;
  logic        rdy2, fs2, ds2, busy2;
  logic [1:0]  st2, fc2, oc2;

  tribuf_phase_ctrl #(.FFT_N(10), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .istream_ready(istream_ready), .istream_done(istream_done),
    .fft_start(fft_start), .fft_done(fft_done),
    .dma_start(dma_start), .dma_done(dma_done),
    .tribuf_status(tribuf_status), .busy(busy),
    .frame_count(frame_count), .overrun_count(overrun_count)
  );

  tribuf_phase_ctrl #(.FFT_N(10), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .enable(enable),
    .istream_ready(rdy2), .istream_done(istream_done),
    .fft_start(fs2), .fft_done(fft_done),
    .dma_start(ds2), .dma_done(dma_done),
    .tribuf_status(st2), .busy(busy2),
    .frame_count(fc2), .overrun_count(oc2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_starts = 0;
  bit mon_on = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic rdy; logic bsy; int ovr; } cyc_exp_t;
  typedef struct { int c; logic [1:0] st; logic fs; logic ds; int frame; } rot_exp_t;
  cyc_exp_t cq[$];
  rot_exp_t rq[$];

  // Reference model: bank roles and engine activity as the environment sees them.
  int m_status = 0, m_frame = 0, m_ovr = 0;
  bit m_fft_valid = 0, m_ready = 0, acc_prev = 0, m_in_full = 0;
  bit fft_out = 0, dma_out = 0, rot_pend = 0, pend_fs = 0, pend_ds = 0;
  int fft_done_at = -1, dma_done_at = -1, start_at = -1, ready_at = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_cycle(input int p_in, input int p_ovr, input int dmin, input int dmax,
                             input int p_stray, input bit allow_in);
    bit fs_now = 0, ds_now = 0;
    if (acc_prev) m_ready = 0;
    acc_prev = 0;
    if (cyc == ready_at) m_ready = 1;
    cq.push_back('{m_ready, fft_out | dma_out, m_ovr});
    if (rot_pend && cyc == start_at) begin
      rot_pend = 0;
      if (pend_fs) begin fft_out = 1; fs_now = 1; fft_done_at = cyc + int'($urandom_range(dmin, dmax)); end
      if (pend_ds) begin dma_out = 1; ds_now = 1; dma_done_at = cyc + int'($urandom_range(dmin, dmax)); end
    end
    istream_done = 0; fft_done = 0; dma_done = 0;
    if (fft_out && cyc == fft_done_at) begin fft_done = 1; fft_out = 0; end
    else if ((!fft_out || fs_now) && int'($urandom_range(0, 99)) < p_stray) fft_done = 1;
    if (dma_out && cyc == dma_done_at) begin dma_done = 1; dma_out = 0; end
    else if ((!dma_out || ds_now) && int'($urandom_range(0, 99)) < p_stray) dma_done = 1;
    if (allow_in) begin
      if (m_ready) begin
        if (int'($urandom_range(0, 99)) < p_in) begin istream_done = 1; acc_prev = 1; m_in_full = 1; end
      end else if (int'($urandom_range(0, 99)) < p_ovr) begin
        istream_done = 1; m_ovr++;
      end
    end
    // All three roles released: the new phase and its starts show two cycles on.
    if (m_in_full && !fft_out && !dma_out && !rot_pend) begin
      rot_pend = 1; start_at = cyc + 2; ready_at = cyc + 3; m_in_full = 0;
      m_status = (m_status + 1) % 3; m_frame++;
      pend_fs = 1; pend_ds = m_fft_valid; m_fft_valid = 1;
      rq.push_back('{start_at, 2'(m_status), 1'b1, pend_ds, m_frame});
    end
    tick();
  endtask

  always @(negedge clk) begin
    cyc_exp_t e;
    rot_exp_t r;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      check("istream_ready", istream_ready, e.rdy);
      check("istream_ready_w2", rdy2, e.rdy);
      check("busy", busy, e.bsy);
      check("overrun_count", overrun_count, e.ovr);
      check("overrun_count_w2", oc2, (e.ovr > 3) ? 3 : e.ovr);
    end
    if (rq.size() > 0 && rq[0].c < cyc) begin
      check("start_missed_cycle", cyc, rq[0].c);
      void'(rq.pop_front());
    end
    if (fft_start || dma_start) begin
      n_starts++;
      if (rq.size() > 0) begin
        r = rq.pop_front();
        check("start_cycle", cyc, r.c);
        check("tribuf_status", tribuf_status, r.st);
        check("tribuf_status_w2", st2, r.st);
        check("fft_start", fft_start, r.fs);
        check("dma_start", dma_start, r.ds);
        check("fft_start_w2", fs2, r.fs);
        check("frame_count", frame_count, r.frame);
        check("frame_count_w2", fc2, r.frame % 4);
      end else if (mon_on) begin
        check("start_without_rotation", {fft_start, dma_start}, 0);
      end
    end
  end

  initial begin
    #400000;
    total++; bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int c_mark;
    rst = 1; enable = 0; istream_done = 0; fft_done = 0; dma_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", istream_ready, 0);
    check("rst_fft_start", fft_start, 0);
    check("rst_dma_start", dma_start, 0);
    check("rst_busy", busy, 0);
    check("rst_status", tribuf_status, 0);
    check("rst_frame", frame_count, 0);
    check("rst_overrun", overrun_count, 0);
    check("rst_overrun_w2", oc2, 0);

    rst = 0; enable = 1; ready_at = cyc + 2; mon_on = 1;
    for (int k = 0; k < 200 && !(m_frame == 6 && !rot_pend); k++)
      model_cycle(100, 0, 1, 1, 0, 1);
    check("six_rotations_frame", frame_count, 6);
    check("six_rotations_status", tribuf_status, 0);

    repeat (2000) model_cycle(30, 10, 1, 6, 5, 1);

    for (int k = 0; k < 200 && (rot_pend || fft_out || dma_out || m_in_full); k++)
      model_cycle(0, 0, 1, 6, 0, 0);
    repeat (3) model_cycle(0, 0, 1, 1, 0, 0);
    mon_on = 0;
    @(negedge clk);
    check("pending_rotations", rq.size(), 0);
    check("quiesce_busy", busy, 0);

    c_mark = n_starts;
    rst = 1; tick();
    rst = 0; enable = 1; tick(); tick();
    check("en_latency_ready", istream_ready, 1);
    check("en_status", tribuf_status, 0);
    check("no_start_on_enable", n_starts, c_mark);

    istream_done = 1; tick(); istream_done = 0;
    check("accept_drops_ready", istream_ready, 0);
    tick();
    check("rot1_fft_start", fft_start, 1);
    check("rot1_dma_start", dma_start, 0);
    check("rot1_status", tribuf_status, 1);
    check("rot1_frame", frame_count, 1);
    tick();
    check("rot1_ready", istream_ready, 1);
    check("rot1_busy", busy, 1);

    istream_done = 1; tick(); istream_done = 0;
    repeat (3) tick();
    check("held_by_fft_status", tribuf_status, 1);
    check("held_by_fft_ready", istream_ready, 0);
    fft_done = 1; tick(); fft_done = 0;
    tick();
    check("rot2_fft_start", fft_start, 1);
    check("rot2_dma_start", dma_start, 1);
    check("rot2_status", tribuf_status, 2);
    check("rot2_frame", frame_count, 2);
    tick();
    check("rot2_ready", istream_ready, 1);
    c_mark = n_starts;

    fft_done = 1; enable = 0; tick(); fft_done = 0;
    check("drain_ready", istream_ready, 0);
    check("drain_busy", busy, 1);
    enable = 1;
    repeat (4) tick();
    check("drain_holds_ready", istream_ready, 0);
    check("drain_holds_busy", busy, 1);
    dma_done = 1; tick(); dma_done = 0;
    check("drain_done_busy", busy, 0);
    check("idle_ready", istream_ready, 0);
    tick();
    check("relaunch_ready_low", istream_ready, 0);
    tick();
    check("relaunch_ready", istream_ready, 1);
    check("relaunch_status_kept", tribuf_status, 2);
    check("no_start_after_drain", n_starts, c_mark);

    istream_done = 1; tick(); istream_done = 0;
    tick();
    check("rot3_fft_start", fft_start, 1);
    check("rot3_dma_start", dma_start, 1);
    check("rot3_status", tribuf_status, 0);
    check("rot3_frame", frame_count, 3);
    tick();
    check("rot3_busy", busy, 1);

    rst = 1; tick();
    rst = 0; enable = 0;
    check("midfft_rst_ready", istream_ready, 0);
    check("midfft_rst_status", tribuf_status, 0);
    check("midfft_rst_busy", busy, 0);
    check("midfft_rst_frame", frame_count, 0);
    check("midfft_rst_starts", {fft_start, dma_start}, 0);
    fft_done = 1; dma_done = 1; istream_done = 1; tick();
    fft_done = 0; dma_done = 0;
    tick(); tick();
    check("late_done_busy", busy, 0);
    check("overrun_three", overrun_count, 3);
    check("overrun_three_w2", oc2, 3);
    check("overrun_status", tribuf_status, 0);
    tick(); tick(); istream_done = 0;
    check("overrun_five", overrun_count, 5);
    check("overrun_sat_w2", oc2, 3);

    enable = 1; tick(); tick();
    check("post_rst_ready", istream_ready, 1);
    istream_done = 1; tick(); istream_done = 0;
    tick();
    check("post_rst_fft_start", fft_start, 1);
    check("post_rst_dma_start", dma_start, 0);
    check("post_rst_status", tribuf_status, 1);
    check("post_rst_frame", frame_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tribuf_phase_ctrl.md
# tribuf_phase_ctrl

Sequencer for the three-bank FFT buffer ring. Tracks which bank holds fresh input, FFT work or DMA results, and rotates `tribuf_status` through PHASE_0 → PHASE_1 → PHASE_2 → PHASE_0 once the input, FFT and DMA roles have all released their banks. On each rotation it issues start pulses to the FFT engine and the DMA engine. It drives `tribuf_status` into the tri-buffer read/write bus muxes and sits between the input streamer, the R2FFT core and the DMA engine.

## Interface
- FFT_N, 10, log2 FFT length; passed through for frame-count width only
- CNT_W, 16, width of `frame_count` and `overrun_count`
- PHASE_0 / PHASE_1 / PHASE_2, 0 / 1 / 2, `tribuf_status` encodings
- clk  in  1  clock; the block has one clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  run request; level
- istream_ready  out  1  input bank is writable
- istream_done  in  1  pulse: input bank is full
- fft_start  out  1  pulse: begin FFT on the FFT-role bank
- fft_done  in  1  pulse: FFT finished
- dma_start  out  1  pulse: begin transfer of the DMA-role bank
- dma_done  in  1  pulse: DMA finished
- tribuf_status  out  2  current phase
- busy  out  1  a started FFT or DMA has not yet returned done
- frame_count  out  CNT_W  number of rotations since reset
- overrun_count  out  CNT_W  number of `istream_done` pulses received while `istream_ready` was low

## Operation
- States: IDLE, WAIT, SWAP, LAUNCH, DRAIN.
- Bank content flags:
  - `fft_valid`: the FFT-role bank holds captured input.
  - `dma_valid`: the DMA-role bank holds a finished FFT.
- Sticky flags:
  - `in_full`: set by `istream_done` while `istream_ready` is high.
  - `fft_busy`: set at `fft_start`, cleared by `fft_done`.
  - `dma_busy`: set at `dma_start`, cleared by `dma_done`.
  - A done pulse with no matching busy flag is ignored.
- IDLE:
  - `istream_ready` = 0.
  - Go to LAUNCH when `enable` = 1. This first launch issues no starts; it only raises `istream_ready`.
- WAIT:
  - Rotate condition: `in_full` && !`fft_busy` && !`dma_busy`. When true, go to SWAP.
  - If `enable` = 0 and `in_full` = 0, go to DRAIN.
- SWAP (1 cycle):
  - `tribuf_status` advances to the next phase; wrap PHASE_2 → PHASE_0.
  - `dma_valid` ← `fft_valid`; `fft_valid` ← 1.
  - Clear `in_full`.
  - `frame_count` += 1, wrapping modulo 2^CNT_W.
- LAUNCH (1 cycle):
  - `fft_start` = `fft_valid`; `dma_start` = `dma_valid`.
  - Set the matching busy flags.
  - `istream_ready` ← 1. Go to WAIT.
- DRAIN:
  - `istream_ready` = 0.
  - When `fft_busy` = `dma_busy` = 0, go to IDLE. `fft_valid`, `dma_valid` and `tribuf_status` are kept.
- `istream_ready`:
  - Falls in the cycle after an accepted `istream_done`.
  - Stays low through SWAP and rises in LAUNCH.
- Overrun: `istream_done` while `istream_ready` = 0 increments `overrun_count`, which saturates at all-ones. The pulse is otherwise ignored.
- Done pulses arriving in SWAP or LAUNCH are captured by the sticky flags.
- A done pulse in the same cycle as the start of the same unit is ignored; the unit is still treated as busy.
- `busy` = `fft_busy` | `dma_busy`.
- `rst` in any state:
  - All state returns to reset values in the next cycle.
  - In-flight units are abandoned; their later done pulses are ignored.

## Timing
- Reset values:
  - `tribuf_status` = PHASE_0.
  - `istream_ready`, `fft_start`, `dma_start`, `busy` = 0.
  - `frame_count`, `overrun_count` = 0.
  - State IDLE; all flags 0.
- All outputs are registered.
- Latency, `enable` rise (cycle t) to `istream_ready` = 1: cycle t+2 (IDLE → LAUNCH → WAIT).
- Latency when the last blocking event (accepted `istream_done`, `fft_done` or `dma_done`) is seen at cycle t:
  - SWAP at t+1.
  - New `tribuf_status` visible at t+2.
  - `fft_start` / `dma_start` high for one cycle at t+2.
  - `istream_ready` high at t+3.
- Minimum rotation period is 3 cycles.

## Structure
- Shared package `r2fft_tribuf_pkg` holds:
  - PHASE_* and MODE_* constants;
  - the state enum `tribuf_state_t`;
  - a function `next_phase()` implementing the wrap.
- The bus muxes import the same phase constants from this package.
- No sub-module. The sticky flags and counters are a few registers each and are inlined.

## Test plan
- Reset then `enable` = 1 → `istream_ready` = 1 after 2 cycles; `tribuf_status` = 0; no start pulses.
- First `istream_done` → `tribuf_status` = 1, `fft_start` pulses, no `dma_start`, `frame_count` = 1.
- Second `istream_done` while FFT is busy → no rotation and `istream_ready` stays 0 until `fft_done`. Then: `tribuf_status` = 2, both starts pulse, `frame_count` = 2.
- Three `istream_done` pulses while `istream_ready` = 0 → `overrun_count` = 3 and `tribuf_status` unchanged. With CNT_W = 2, five such pulses → `overrun_count` = 3 (saturated).
- Six full rotations with immediate done responses → `tribuf_status` sequence 1, 2, 0, 1, 2, 0; `frame_count` = 6; rotation period = 3 cycles.
- Drop `enable` with DMA busy → DRAIN, then IDLE only after `dma_done`. Assert `rst` mid-FFT → all outputs return to reset values; a later `fft_done` has no effect.
